sgb_packet_rx: RTL and testbench

Super Game Boy command-packet receiver. Sits directly downstream of the Game Boy core's `joy_p54` output and decodes the P14/P15 pulse protocol into 16-byte SGB packets. Completed packets are double-buffered for the SNES-side ICD2 register interface to read and acknowledge. It runs in the Game Boy clock domain and samples on the core's clock enable.

---
 rtl/sgb_packet_rx.sv | 161 ++++++++++++++++
 tb/tb_sgb_packet_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sgb_packet_rx.sv
// Super Game Boy command-packet receiver.
// Decodes the P14/P15 pulse protocol from the GB joypad select lines into
// 16-byte packets and double-buffers them for the SNES-side ICD2 reader.
//
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   clk_en          GB CPU clock enable; joy_p54 sampled only on these ticks
//   joy_p54         select lines, [0]=P14, [1]=P15
//   pkt_rd_addr     byte index into the output buffer
//   pkt_rd_data     registered output-buffer byte (1 clk latency)
//   pkt_valid       a complete packet is held in the output buffer
//   pkt_ack         single-clk "packet consumed" pulse from the SNES side
//   pkt_overrun     sticky: a packet completed while pkt_valid was set
//   rx_busy         a packet is in progress
module sgb_packet_rx #(
    parameter int TIMEOUT = 70224
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en,
    input  logic [1:0] joy_p54,
    input  logic [3:0] pkt_rd_addr,
    output logic [7:0] pkt_rd_data,
    output logic       pkt_valid,
    input  logic       pkt_ack,
    output logic       pkt_overrun,
    output logic       rx_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_HI,
        S_RECV
    } state_t;

    localparam logic [16:0] TMO_LIM = 17'(TIMEOUT);
    localparam logic [1:0]  L_HIGH  = 2'b11;
    localparam logic [1:0]  L_RST   = 2'b00;
    localparam logic [1:0]  L_B0    = 2'b10;
    localparam logic [1:0]  L_B1    = 2'b01;

    state_t      state_q;
    logic [1:0]  p_q;
    logic [7:0]  bit_cnt_q;
    logic [16:0] tmo_q;
    logic [7:0]  stg_q  [16];
    logic [7:0]  obuf_q [16];
    logic        valid_q;
    logic        ovr_q;
    logic        busy_q;
    logic [7:0]  rd_q;

    logic        pulse;
    logic [16:0] tmo_d;
    logic        tmo_hit;
    logic        can_load;

    // A pulse is a change to any non-idle level; a held level counts once.
    assign pulse    = clk_en && (joy_p54 != p_q) && (joy_p54 != L_HIGH);
    assign tmo_d    = (tmo_q == '1) ? tmo_q : tmo_q + 17'd1;
    assign tmo_hit  = (tmo_d >= TMO_LIM);
    // An ack on the commit edge frees the output buffer for the new packet.
    assign can_load = !valid_q || pkt_ack;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            p_q       <= L_HIGH;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
            rd_q      <= '0;
            for (int i = 0; i < 16; i++) begin
                stg_q[i]  <= '0;
                obuf_q[i] <= '0;
            end
        end else begin
            rd_q <= obuf_q[pkt_rd_addr];

            // Commit logic below overrides these when both hit one edge.
            if (pkt_ack) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end

            if (clk_en) begin
                p_q <= joy_p54;

                if (pulse && joy_p54 == L_RST) begin
                    for (int i = 0; i < 16; i++) begin
                        stg_q[i] <= '0;
                    end
                    bit_cnt_q <= '0;
                    tmo_q     <= '0;
                    state_q   <= S_WAIT_HI;
                    busy_q    <= 1'b1;
                end else begin
                    unique case (state_q)
                        S_IDLE: begin
                            tmo_q <= '0;
                        end
                        S_WAIT_HI: begin
                            if (joy_p54 == L_HIGH) begin
                                state_q <= S_RECV;
                                tmo_q   <= '0;
                            end else if (tmo_hit) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                tmo_q   <= '0;
                            end else begin
                                tmo_q <= tmo_d;
                            end
                        end
                        S_RECV: begin
                            if (pulse) begin
                                tmo_q <= '0;
                                if (!bit_cnt_q[7]) begin
                                    stg_q[bit_cnt_q[6:3]][bit_cnt_q[2:0]]
                                        <= (joy_p54 == L_B1);
                                    bit_cnt_q <= bit_cnt_q + 8'd1;
                                    state_q   <= S_WAIT_HI;
                                end else begin
                                    // 129th pulse is the stop bit.
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                    if (joy_p54 == L_B0) begin
                                        if (can_load) begin
                                            obuf_q  <= stg_q;
                                            valid_q <= 1'b1;
                                            ovr_q   <= 1'b0;
                                        end else begin
                                            ovr_q <= 1'b1;
                                        end
                                    end
                                end
                            end else if (tmo_hit) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                tmo_q   <= '0;
                            end else begin
                                tmo_q <= tmo_d;
                            end
                        end
                        default: begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign pkt_rd_data = rd_q;
    assign pkt_valid   = valid_q;
    assign pkt_overrun = ovr_q;
    assign rx_busy     = busy_q;

endmodule

// File: tb/tb_sgb_packet_rx.sv
// Directed bench for sgb_packet_rx.
// Output-buffer reads are scored against a bench-side packet model.
module tb_sgb_packet_rx;

    localparam int TMO = 70224;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clk_en;
    logic [1:0] joy_p54;
    logic [3:0] pkt_rd_addr;
    logic [7:0] pkt_rd_data;
    logic       pkt_valid;
    logic       pkt_ack;
    logic       pkt_overrun;
    logic       rx_busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [127:0] m_buf;
    logic         m_valid;
    logic         m_ovr;
    logic [7:0]   exp_q [$];

    sgb_packet_rx #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_en      (clk_en),
        .joy_p54     (joy_p54),
        .pkt_rd_addr (pkt_rd_addr),
        .pkt_rd_data (pkt_rd_data),
        .pkt_valid   (pkt_valid),
        .pkt_ack     (pkt_ack),
        .pkt_overrun (pkt_overrun),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [1:0] v);
        joy_p54 = v;
        clk_en  = 1'b1;
        @(posedge clk); #1;
        clk_en  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_reset();
        tick(2'b00);
        tick(2'b11);
    endtask

    // Every 7th bit holds its pulse for an extra tick.
    task automatic send_bits(input logic [127:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            tick(d[i] ? 2'b01 : 2'b10);
            if (i % 7 == 0) tick(d[i] ? 2'b01 : 2'b10);
            tick(2'b11);
        end
    endtask

    task automatic send_stop(input string tag, input logic [127:0] d,
                             input logic [1:0] s, input logic ack,
                             input logic armed);
        joy_p54 = s;
        clk_en  = 1'b1;
        pkt_ack = ack;
        @(posedge clk); #1;
        clk_en  = 1'b0;
        pkt_ack = 1'b0;
        if (armed && s == 2'b10) begin
            if (!m_valid || ack) begin
                m_buf   = d;
                m_valid = 1'b1;
                m_ovr   = 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (ack) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        check({tag, ".valid"}, pkt_valid, m_valid);
        check({tag, ".ovr"}, pkt_overrun, m_ovr);
        check({tag, ".busy"}, rx_busy, 1'b0);
        tick(2'b11);
    endtask

    task automatic send_pkt(input string tag, input logic [127:0] d,
                            input logic [1:0] s, input logic ack);
        send_reset();
        check({tag, ".busy_on"}, rx_busy, 1'b1);
        send_bits(d, 128);
        check({tag, ".busy_pre"}, rx_busy, 1'b1);
        send_stop(tag, d, s, ack, 1'b1);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 16; a++) begin
            pkt_rd_addr = 4'(a);
            exp_q.push_back(m_buf[a*8 +: 8]);
            @(posedge clk); #1;
            check($sformatf("%s.rd%0d", tag, a), pkt_rd_data,
                  exp_q.pop_front());
        end
    endtask

    task automatic do_ack(input string tag);
        pkt_ack = 1'b1;
        @(posedge clk); #1;
        pkt_ack = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        check({tag, ".valid"}, pkt_valid, 1'b0);
        check({tag, ".ovr"}, pkt_overrun, 1'b0);
    endtask

    initial begin
        reset_n     = 1'b0;
        clk_en      = 1'b0;
        joy_p54     = 2'b11;
        pkt_rd_addr = '0;
        pkt_ack     = 1'b0;
        m_buf       = '0;
        m_valid     = 1'b0;
        m_ovr       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.rd", pkt_rd_data, 8'h00);
        reset_n = 1'b1;
        check("rst.valid", pkt_valid, 1'b0);
        check("rst.ovr", pkt_overrun, 1'b0);
        check("rst.busy", rx_busy, 1'b0);
        read_all("rst");

        // Idle-state data pulses are ignored.
        tick(2'b10);
        tick(2'b11);
        check("idle.busy", rx_busy, 1'b0);

        send_pkt("good", 128'h0189, 2'b10, 1'b0);
        read_all("good");

        send_pkt("ovr", {16{8'h11}}, 2'b10, 1'b0);
        read_all("ovr");
        do_ack("ovr_ack");

        send_pkt("badstop", {16{8'h5a}}, 2'b01, 1'b0);
        read_all("badstop");

        send_reset();
        send_bits({16{8'hff}}, 40);
        send_pkt("restart", {16{8'ha5}}, 2'b10, 1'b0);
        read_all("restart");
        do_ack("restart_ack");

        send_reset();
        send_bits(128'h3ff, 10);
        joy_p54 = 2'b11;
        clk_en  = 1'b1;
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo.busy_pre", rx_busy, 1'b1);
        @(posedge clk); #1;
        check("tmo.busy", rx_busy, 1'b0);
        clk_en = 1'b0;
        send_bits({16{8'h77}}, 128);
        check("tmo.idle", rx_busy, 1'b0);
        send_stop("tmo", {16{8'h77}}, 2'b10, 1'b0, 1'b0);
        read_all("tmo");

        send_pkt("pre44", {16{8'h44}}, 2'b10, 1'b0);
        send_pkt("pre66", {16{8'h66}}, 2'b10, 1'b0);
        send_pkt("coll", {16{8'h22}}, 2'b10, 1'b1);
        read_all("coll");

        send_reset();
        send_bits({16{8'hc3}}, 20);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_buf   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        check("midrst.busy", rx_busy, 1'b0);
        check("midrst.valid", pkt_valid, 1'b0);
        check("midrst.ovr", pkt_overrun, 1'b0);
        read_all("midrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
